// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared types and constants for the store buffer
package params_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } sb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RESP
    } sb_state_t;

endpackage

// File: rtl/sb_fifo.sv
// rtl/sb_fifo.sv - store entry FIFO with a combinational head read port
module sb_fifo
    import params_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  sb_entry_t   push_entry_i,
    input  logic        pop_i,
    output sb_entry_t   head_o,
    output logic [AW:0] count_o,
    output logic        full_o
);

    sb_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [AW:0]       count_q, count_d;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        head_d  = pop_i  ? head_q + 1'b1 : head_q;
        tail_d  = push_i ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[tail_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer draining to AXI4-Lite
module store_buffer
    import params_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ST_VALID,
    input  logic [31:0] ST_ADDR,
    input  logic [31:0] ST_WDATA,
    input  logic [3:0]  ST_WSTRB,
    output logic        ST_READY,
    output logic        SB_EMPTY,
    output logic        BUS_ERR_VALID,
    output logic [31:0] BUS_ERR_ADDR,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY
);

    localparam int AW = $clog2(DEPTH);

    sb_state_t   state_q, state_d;
    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        err_valid_q, err_valid_d;
    logic [31:0] err_addr_q;

    sb_entry_t   head;
    sb_entry_t   push_entry;
    logic [AW:0] count;
    logic        full;
    logic        push, pop;
    logic        aw_hs, w_hs;

    assign push_entry = '{addr: ST_ADDR, data: ST_WDATA, strb: ST_WSTRB};
    assign push       = ST_VALID && ST_READY;
    assign pop        = M_AXI_BVALID && M_AXI_BREADY;
    assign aw_hs      = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs       = M_AXI_WVALID && M_AXI_WREADY;

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (CLK),
        .rst_i        (RST),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count),
        .full_o       (full)
    );

    always_comb begin
        state_d     = state_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        err_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Looking at push too lets a store into an empty buffer hit the bus next cycle.
                if (count != '0 || push) begin
                    state_d    = SEND;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            SEND: begin
                if (aw_hs) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_hs) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (M_AXI_BVALID) begin
                    err_valid_d = (M_AXI_BRESP != AXI_RESP_OKAY);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            err_valid_q <= err_valid_d;
            if (err_valid_d) begin
                err_addr_q <= head.addr;
            end
        end
    end

    // Handshake outputs are gated by RST so a reset drops them in the same cycle.
    assign ST_READY      = !RST && !full;
    assign SB_EMPTY      = (count == '0);
    assign M_AXI_AWVALID = aw_valid_q && !RST;
    assign M_AXI_WVALID  = w_valid_q && !RST;
    assign M_AXI_BREADY  = (state_q == RESP) && !RST;
    assign M_AXI_AWADDR  = {head.addr[31:2], 2'b00};
    assign M_AXI_WDATA   = head.data;
    assign M_AXI_WSTRB   = head.strb;
    assign BUS_ERR_VALID = err_valid_q;
    assign BUS_ERR_ADDR  = err_addr_q;

endmodule
